// File: rtl/led_sched_if.sv
// led_sched_if: event-source / fade-trigger bundle for the LED event scheduler
//  en        master->slave  grant enable (0 = accumulate only)
//  event_in  master->slave  per-source event strobes
//  clr_ovf   master->slave  clear all sticky overflow flags
//  trigger   slave->master  one-hot fade trigger pulses
//  busy      slave->master  hold-off in progress
//  pending   slave->master  any source has queued events
//  overflow  slave->master  sticky per-source event-lost flags
interface led_sched_if #(parameter int NUM_REQ = 4);
  logic en, clr_ovf, busy, pending;
  logic [NUM_REQ-1:0] event_in, trigger, overflow;
  modport master(output en, event_in, clr_ovf, input trigger, busy, pending, overflow);
  modport slave(input en, event_in, clr_ovf, output trigger, busy, pending, overflow);
endinterface

// File: rtl/led_event_sched.sv
// led_event_sched: round-robin LED fade trigger scheduler with pending counters and hold-off
//  clk   system clock
//  rstn  asynchronous active-low reset
//  bus   led_sched_if slave: en/event_in/clr_ovf in, trigger/busy/pending/overflow out
module led_event_sched #(
  parameter int NUM_REQ = 4,
  parameter int PEND_BITS = 4,
  parameter int HOLD_BITS = 24,
  parameter logic [HOLD_BITS-1:0] HOLDOFF = 24'd8000000
) (
  input logic clk,
  input logic rstn,
  led_sched_if.slave bus
);
  localparam int W = $clog2(NUM_REQ);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;
  logic [PEND_BITS-1:0] cnt [NUM_REQ];
  logic [NUM_REQ-1:0] nz, gv, trig, ovf;
  logic [W-1:0] ptr, win;
  logic [HOLD_BITS-1:0] hold;
  logic busy, grant;
  int j;
  // Scan downward so the nearest nonzero source after ptr is the last write.
  always_comb begin
    j = 0;
    win = ptr;
    for (int i = 0; i < NUM_REQ; i++) nz[i] = |cnt[i];
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      win = nz[W'(j)] ? W'(j) : win;
    end
  end
  assign grant = (state == IDLE) && bus.en && |nz;
  assign gv = grant ? NUM_REQ'(1) << win : '0;
  assign bus.trigger = trig;
  assign bus.busy = busy;
  assign bus.pending = |nz;
  assign bus.overflow = ovf;
  // A grant and an event in the same cycle cancel, which also lets a saturated counter absorb a new event.
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.event_in[i] && !gv[i] && !(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
        else if (!bus.event_in[i] && gv[i]) cnt[i] <= cnt[i] - 1'b1;
        ovf[i] <= !bus.clr_ovf && (ovf[i] || (bus.event_in[i] && !gv[i] && &cnt[i]));
      end
    end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      trig <= '0;
      busy <= 1'b0;
      hold <= '0;
      ptr <= W'(NUM_REQ - 1);
    end else if (state == IDLE) begin
      trig <= gv;
      busy <= 1'b0;
      if (grant) begin
        ptr <= win;
        hold <= HOLDOFF;
        state <= HOLD;
      end
    end else begin
      trig <= '0;
      busy <= 1'b1;
      if (hold == '0) state <= IDLE;
      else hold <= hold - 1'b1;
    end
endmodule

// File: tb/tb_led_event_sched.sv
// tb_led_event_sched: directed table, corner sequences and random run against a cycle-level model
module tb_led_event_sched;
  localparam int N = 4, H = 5, MAXC = 3;
  typedef struct {
    logic en; logic [3:0] ev; logic clr;
    logic [3:0] trig; logic busy; logic pend; logic [3:0] ovf;
  } vec_t;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  led_sched_if #(.NUM_REQ(N)) bus();
  led_event_sched #(.NUM_REQ(N), .PEND_BITS(2), .HOLD_BITS(24), .HOLDOFF(24'd5)) dut (
    .clk(clk), .rstn(rstn), .bus(bus));
  vec_t tbl[15];
  int n_chk = 0, n_fail = 0;
  int mc[N];
  int mptr, next_ok, last_g, edge_n = 0;
  logic [3:0] mtrig, movf, prev_trig = '0;
  logic [3:0] tq[$];
  int te[$];

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", n, a, e, edge_n);
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) mc[i] = 0;
    mptr = N - 1; next_ok = 0; last_g = -1000; mtrig = '0; movf = '0;
  endtask

  // Behavioural view: a grant may happen once H+2 edges have passed since the last one.
  task automatic model_edge();
    int w, n, any;
    logic [3:0] g;
    g = '0; w = -1; any = 0;
    for (int i = 0; i < N; i++) if (mc[i] > 0) any = 1;
    if (edge_n >= next_ok && bus.en && any == 1) begin
      for (int k = 1; k <= N; k++) if (w < 0 && mc[(mptr + k) % N] > 0) w = (mptr + k) % N;
      g[w] = 1'b1; mptr = w; next_ok = edge_n + H + 2; last_g = edge_n;
    end
    mtrig = g;
    for (int i = 0; i < N; i++) begin
      n = mc[i] + int'(bus.event_in[i]) - int'(g[i]);
      if (n > MAXC) begin
        n = MAXC;
        movf[i] = 1'b1;
      end
      mc[i] = n;
      if (bus.clr_ovf) movf[i] = 1'b0;
    end
  endtask

  function automatic logic mbusy();
    return rstn && edge_n >= last_g + 1 && edge_n <= last_g + H + 1;
  endfunction

  function automatic logic mpend();
    logic p = 1'b0;
    for (int i = 0; i < N; i++) if (mc[i] > 0) p = 1'b1;
    return p;
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (rstn) model_edge();
    #1;
    chk("trigger", 32'(bus.trigger), 32'(mtrig));
    chk("busy", 32'(bus.busy), 32'(mbusy()));
    chk("pending", 32'(bus.pending), 32'(mpend()));
    chk("overflow", 32'(bus.overflow), 32'(movf));
    chk("onehot", 32'($onehot0(bus.trigger)), 32'd1);
    chk("gap", 32'(prev_trig != 0 && bus.trigger != 0), 32'd0);
    prev_trig = bus.trigger;
    if (bus.trigger != 0) begin
      tq.push_back(bus.trigger);
      te.push_back(edge_n);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'b0100, 1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000};
    tbl[1] = '{1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0, 4'b0000};
    for (int i = 2; i < 8; i++) tbl[i] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000};
    tbl[8] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000};
    for (int i = 9; i < 14; i++)
      tbl[i] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, (i >= 12) ? 4'b0001 : 4'b0000};
    tbl[14] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 4'b0000};

    // reset with all sources strobing, then round-robin order from source 0
    bus.en = 1'b1; bus.event_in = 4'hF; bus.clr_ovf = 1'b0;
    do_reset();
    chk("rst_trig", 32'(bus.trigger), 32'd0);
    chk("rst_pend", 32'(bus.pending), 32'd0);
    tq.delete(); te.delete();
    tick();
    bus.event_in = '0;
    repeat (30) tick();
    chk("rr_count", 32'(tq.size() >= 4), 32'd1);
    if (tq.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        chk("rr_order", 32'(tq[i]), 32'(4'b0001 << i));
        if (i > 0) chk("rr_spacing", 32'(te[i] - te[i-1]), 32'(H + 2));
      end

    // single event, then saturation with en=0 and overflow clear
    bus.event_in = '0;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      bus.en = tbl[i].en; bus.event_in = tbl[i].ev; bus.clr_ovf = tbl[i].clr;
      tick();
      chk($sformatf("tbl%0d_trig", i), 32'(bus.trigger), 32'(tbl[i].trig));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_pend", i), 32'(bus.pending), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d_ovf", i), 32'(bus.overflow), 32'(tbl[i].ovf));
    end
    bus.clr_ovf = 1'b0; bus.event_in = '0; bus.en = 1'b1;
    tq.delete(); te.delete();
    repeat (30) tick();
    chk("sat_pulses", 32'(tq.size()), 32'd3);
    foreach (tq[i]) chk("sat_src", 32'(tq[i]), 32'd1);

    // fairness: source 1 continuous, source 3 once
    do_reset();
    tq.delete(); te.delete();
    bus.event_in = 4'b1010;
    tick();
    bus.event_in = 4'b0010;
    repeat (30) tick();
    chk("fair_count", 32'(tq.size() >= 4), 32'd1);
    if (tq.size() >= 4) begin
      chk("fair_0", 32'(tq[0]), 32'b0010);
      chk("fair_1", 32'(tq[1]), 32'b1000);
      chk("fair_2", 32'(tq[2]), 32'b0010);
      chk("fair_3", 32'(tq[3]), 32'b0010);
    end

    // event on the grant cycle keeps the count at 1
    bus.event_in = '0;
    do_reset();
    tq.delete(); te.delete();
    bus.event_in = 4'b0001;
    tick();
    tick();
    bus.event_in = '0;
    repeat (15) tick();
    chk("incdec_pulses", 32'(tq.size()), 32'd2);
    if (tq.size() == 2) chk("incdec_spacing", 32'(te[1] - te[0]), 32'(H + 2));

    // asynchronous reset in the middle of hold-off
    do_reset();
    bus.event_in = 4'b0011;
    tick();
    bus.event_in = '0;
    tick();
    tick();
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_pend", 32'(bus.pending), 32'd0);
    chk("arst_trig", 32'(bus.trigger), 32'd0);
    model_reset();
    tick();
    tick();
    rstn = 1'b1;
    tq.delete(); te.delete();
    repeat (20) tick();
    chk("arst_no_trig", 32'(tq.size()), 32'd0);

    // random traffic against the model
    do_reset();
    repeat (1500) begin
      bus.en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) bus.event_in[i] = ($urandom_range(0, 7) == 0);
      bus.clr_ovf = ($urandom_range(0, 49) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
